// File: rtl/seq_normalizer.sv
// Sequential left-normalizer: shifts a nonzero operand left one bit per clock
// until its MSB is set, reporting the shift count (leading-zero count).
module seq_normalizer #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    shift_count,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic             zero_q, zero_d;
  // Low for the first edge after reset release, so a start coincident with
  // deassertion is never accepted regardless of edge ordering.
  logic             armed_q, armed_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      result_q <= '0;
      count_q  <= '0;
      zero_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      zero_q   <= zero_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    zero_d   = zero_q;
    armed_d  = 1'b1;
    ready    = 1'b0;
    valid    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start && armed_q) begin
          result_d = operand;
          count_d  = '0;
          if (operand == '0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (result_q[WIDTH-1]) begin
          state_d = DONE;
        end else begin
          result_d = {result_q[WIDTH-2:0], 1'b0};
          count_d  = count_q + CW'(1);
        end
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result      = result_q;
  assign shift_count = count_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer: directed and random operands checked
// against a leading-zero model computed from the highest set bit.
module tb_seq_normalizer;
  localparam int WIDTH = 32;
  localparam int CW    = 5;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] operand = '0;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    shift_count;
  logic             zero;

  int errors = 0;
  int checks = 0;

  seq_normalizer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .operand(operand),
    .ready(ready),
    .valid(valid),
    .result(result),
    .shift_count(shift_count),
    .zero(zero)
  );

  always #5 CLK = ~CLK;

  // Expected outcome from the position of the highest set bit.
  function automatic void model(input logic [WIDTH-1:0] op, output logic [WIDTH-1:0] r,
                                output int k, output logic z);
    longint unsigned wide;
    int p;
    z = (op == '0);
    if (z) begin
      k = 0;
      r = '0;
    end else begin
      wide = longint'(op) + 64'd1;
      p = $clog2(wide) - 1;
      k = WIDTH - 1 - p;
      r = op << k;
    end
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] op, input bit hold, input string name);
    logic [WIDTH-1:0] er;
    int ek, edges, exp_edges;
    logic ez;
    model(op, er, ek, ez);
    exp_edges = ez ? 0 : ek + 1;
    @(negedge CLK);
    start = 1'b1;
    operand = op;
    @(posedge CLK);
    #1;
    if (hold) operand = '1;
    else begin
      start = 1'b0;
      operand = $urandom;
    end
    edges = 0;
    while (!valid && edges < 40) begin
      @(posedge CLK);
      #1;
      edges++;
    end
    start = 1'b0;
    chk({name, " latency"}, edges, exp_edges);
    chk({name, " result"}, result, er);
    chk({name, " shift_count"}, {27'b0, shift_count}, ek);
    chk({name, " zero"}, {31'b0, zero}, {31'b0, ez});
    chk({name, " ready during valid"}, {31'b0, ready}, 32'd0);
    @(posedge CLK);
    #1;
    chk({name, " valid one cycle"}, {31'b0, valid}, 32'd0);
    chk({name, " ready after valid"}, {31'b0, ready}, 32'd1);
    @(posedge CLK);
    #1;
    chk({name, " result hold"}, result, er);
    chk({name, " count hold"}, {27'b0, shift_count}, ek);
  endtask

  task automatic test_reset();
    #2;
    chk("reset ready", {31'b0, ready}, 32'd1);
    chk("reset valid", {31'b0, valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset shift_count", {27'b0, shift_count}, 32'd0);
    chk("reset zero", {31'b0, zero}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_directed();
    run_op(32'h0000_0004, 1'b0, "op4");
    run_op(32'h8000_0000, 1'b0, "msb");
    run_op(32'h0000_0001, 1'b0, "one");
    run_op(32'h0000_0000, 1'b0, "zero_op");
  endtask

  task automatic test_start_ignored();
    run_op(32'h0001_2345, 1'b1, "held_start");
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge CLK);
    start = 1'b1;
    operand = 32'h0000_00FF;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst ready", {31'b0, ready}, 32'd1);
    chk("midrst valid", {31'b0, valid}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst shift_count", {27'b0, shift_count}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (valid) seen = 1'b1;
    end
    chk("midrst no valid", {31'b0, seen}, 32'd0);
    run_op(32'h4000_0000, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] op;
    for (int i = 0; i < 16; i++) begin
      op = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 3) op = '0;
      run_op(op, 1'b0, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    run_op(32'h0000_8000, 1'b0, "b2b_a");
    run_op(32'h7FFF_FFFF, 1'b0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
